// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding, NOP and buffer entry width.
// Used by fetch_ctrl and fetch_buf.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int          INSN_W   = 32;

    // A buffer entry is {instruction, pc}.
    function automatic int entry_w(input int width);
        return INSN_W + width;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// 2-entry instruction buffer; head drives decode straight from registers (NOP when empty).
// Latency: push visible at head next cycle; flush dominates push/pop; never refuses (caller guarantees space).
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]      NOP      = NOP_INSN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [31:0]      push_ins,
    input  logic [WIDTH-1:0] push_pc,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic             head_vld,
    output logic [31:0]      head_ins,
    output logic [WIDTH-1:0] head_pc
);

    localparam int EW = entry_w(WIDTH);

    logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [EW-1:0] din;
    logic          pop_ok;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        din    = {push_ins, push_pc};
        pop_ok = pop && (cnt_q != 2'd0);
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_d = din;
                    else               ent1_d = din;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_d = din;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= {NOP, RESET_PC};
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count    = cnt_q;
    assign head_vld = (cnt_q != 2'd0);
    assign head_ins = head_vld ? ent0_q[EW-1 -: 32] : NOP;
    assign head_pc  = ent0_q[WIDTH-1:0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one-at-a-time imem requests, buffers 2 instructions for decode.
// Latency: first valid 2 cycles after reset; decode stall throttles issue via credit. Macro FETCH_PERF_EN adds perf counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]      NOP      = NOP_INSN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch,
    input  logic             ALU_zero,
    input  logic [WIDTH-1:0] PC_JMP,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instruction,
    output logic [WIDTH-1:0] PC,
    output logic             valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      squash_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             taken, ack_acc, pop, push, credit;
    logic [1:0]       cnt, occ_next;
    logic [WIDTH-1:0] target;

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign taken     = branch & ALU_zero;
    assign ack_acc   = imem_req & imem_ack;
    assign pop       = valid & ~stall;
    assign push      = ack_acc & (state_q == BUSY) & ~taken;
    assign target    = PC_JMP & ~WIDTH'(3);
    // Only one request is ever in flight, so a new one fits if the buffer is below 2 after this cycle.
    assign occ_next  = taken ? 2'd0 : (cnt + {1'b0, push} - {1'b0, pop});
    assign credit    = (occ_next < 2'd2);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        unique case (state_q)
            IDLE: begin
                if (taken) begin
                    fetch_pc_d = target;
                    addr_d     = target;
                    state_d    = BUSY;
                end else if (credit) begin
                    addr_d  = fetch_pc_q;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (taken) begin
                    fetch_pc_d = target;
                    if (ack_acc) addr_d  = target;
                    else         state_d = DRAIN;
                end else if (ack_acc) begin
                    fetch_pc_d = addr_q + WIDTH'(4);
                    if (credit) addr_d  = addr_q + WIDTH'(4);
                    else        state_d = IDLE;
                end
            end
            DRAIN: begin
                // Address stays held until the wrong-path ack arrives; its data is dropped.
                if (taken) fetch_pc_d = target;
                if (ack_acc) begin
                    if (taken || credit) begin
                        addr_d  = taken ? target : fetch_pc_q;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_buf #(
        .WIDTH   (WIDTH),
        .RESET_PC(RESET_PC),
        .NOP     (NOP)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_ins(imem_rdata),
        .push_pc (imem_addr),
        .pop     (pop),
        .flush   (taken),
        .count   (cnt),
        .head_vld(valid),
        .head_ins(instruction),
        .head_pc (PC)
    );

`ifdef FETCH_PERF_EN
    logic        squash;
    logic [31:0] fetch_cnt_q, fetch_cnt_d, squash_cnt_q, squash_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        squash       = ack_acc & (((state_q == BUSY) & taken) | (state_q == DRAIN));
        fetch_cnt_d  = fetch_cnt_q + {31'd0, pop};
        squash_cnt_d = squash_cnt_q + {31'd0, squash};
        stall_cnt_d  = stall_cnt_q + {31'd0, valid & stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a queue-based model of the
// delivered instruction stream (in-order PCs, restart at redirect target, wrong-path data never seen).
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, branch, ALU_zero, stall, imem_ack;
    logic [31:0] PC_JMP, imem_rdata, imem_addr, instruction, PC;
    logic        imem_req, valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, squash_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .branch     (branch),
        .ALU_zero   (ALU_zero),
        .PC_JMP     (PC_JMP),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .PC         (PC),
        .valid      (valid)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .squash_cnt (squash_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_fetch;
    bit          stale;
    int          errors = 0;
    int          checks = 0;
    int          ack_mode, lat, wcnt, cyc;
    bit          prev_rst, prev_req, prev_acc;
    logic [31:0] prev_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic br, input logic z,
                        input logic [31:0] jmp);
        logic ack, acc, taken;
        case (ack_mode)
            0:       ack = 1'b1;
            1:       ack = (wcnt >= lat);
            default: ack = ($urandom_range(0, 2) == 0);
        endcase
        rst = r; stall = st; branch = br; ALU_zero = z; PC_JMP = jmp; imem_ack = ack;
        acc   = imem_req & ack;
        taken = br & z;
        if (!prev_rst && prev_req && !prev_acc) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        prev_rst = r; prev_req = imem_req; prev_acc = acc; prev_addr = imem_addr;
        if (r) begin
            q.delete();
            exp_fetch = 32'h0;
            stale     = 1'b0;
        end else if (taken) begin
            q.delete();
            exp_fetch = jmp & ~32'h3;
            stale     = imem_req & ~acc;
        end else begin
            if (q.size() > 0 && !st) void'(q.pop_front());
            if (acc) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    chk("fetch_addr", imem_addr, exp_fetch);
                    q.push_back('{pc: imem_addr, ins: mem_word(imem_addr)});
                    exp_fetch = exp_fetch + 32'd4;
                    chk("no_overflow", q.size() <= 2, 1);
                end
            end
        end
        if (r || !imem_req || acc) wcnt = 0;
        else                        wcnt++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("valid", valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("head_pc", PC, q[0].pc);
            chk("head_ins", instruction, q[0].ins);
        end else begin
            chk("nop_when_empty", instruction, NOPV);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h, pcs[$];
        int          acks, cycs[$];
        bit          found, saw8;

        rst = 1'b1; stall = 0; branch = 0; ALU_zero = 0; PC_JMP = 0; imem_ack = 0;
        ack_mode = 0; lat = 3; wcnt = 0; cyc = 0; stale = 0; exp_fetch = 0;
        prev_rst = 1; prev_req = 0; prev_acc = 0; prev_addr = 0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ins", instruction, NOPV);
        chk("rst_pc", PC, 0);

        // Zero-wait streaming
        step(0, 0, 0, 0, 0);
        chk("stream_req_c1", imem_req, 1);
        chk("stream_addr_c1", imem_addr, 0);
        step(0, 0, 0, 0, 0);
        chk("stream_valid_c2", valid, 1);
        chk("stream_pc_c2", PC, 0);
        chk("stream_ins_c2", instruction, mem_word(0));
        step(0, 0, 0, 0, 0);
        chk("stream_pc_c3", PC, 4);
        step(0, 0, 0, 0, 0);
        chk("stream_pc_c4", PC, 8);
        chk("stream_addr_c4", imem_addr, 12);

        // Stall backpressure
        h = PC; acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req) acks++;
            step(0, 1, 0, 0, 0);
            chk("stall_head_held", PC, h);
        end
        chk("stall_acks_le2", acks <= 2, 1);
        chk("stall_req_drop", imem_req, 0);
        step(0, 0, 0, 0, 0);
        chk("stall_release_next", PC, h + 32'd4);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

        // Slow memory, ack 3 cycles after request
        ack_mode = 1; lat = 3;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            if (valid) begin cycs.push_back(cyc); pcs.push_back(PC); end
        end
        chk("slow_count", pcs.size() >= 3, 1);
        if (pcs.size() >= 3) begin
            chk("slow_pc0", pcs[0], 0);
            chk("slow_pc1", pcs[1], 4);
            chk("slow_pc2", pcs[2], 8);
            chk("slow_gap1", cycs[1] - cycs[0], 4);
            chk("slow_gap2", cycs[2] - cycs[1], 4);
        end

        // Redirect while a request is outstanding
        step(1, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == 32'h8) found = 1;
            else step(0, 0, 0, 0, 0);
        end
        chk("drain_req8_seen", found, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h100);
        chk("drain_req_held", imem_req, 1);
        chk("drain_addr_held", imem_addr, 8);
        found = 0; saw8 = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (valid && PC == 32'h8) saw8 = 1;
            if (imem_req && imem_addr == 32'h100) found = 1;
            else step(0, 0, 0, 0, 0);
        end
        chk("drain_next_addr", found, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (valid && PC == 32'h8) saw8 = 1;
            if (valid) found = 1;
            else step(0, 0, 0, 0, 0);
        end
        chk("drain_first_valid", found, 1);
        chk("drain_first_pc", PC, 32'h100);
        chk("drain_no_pc8", saw8, 0);

        // Redirect coincident with ack, misaligned target
        ack_mode = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("coin_req", imem_req, 1);
        step(0, 0, 1, 1, 32'h203);
        chk("coin_flush", valid, 0);
        chk("coin_addr", imem_addr, 32'h200);
        chk("coin_req_after", imem_req, 1);
        step(0, 0, 0, 0, 0);
        chk("coin_first_pc", PC, 32'h200);

        // Reset with two entries buffered and decode stalled
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("mid_valid_before", valid, 1);
        step(1, 1, 0, 0, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ins", instruction, NOPV);
        chk("mid_rst_req", imem_req, 0);
`ifdef FETCH_PERF_EN
        chk("mid_rst_fetch_cnt", fetch_cnt, 0);
        chk("mid_rst_squash_cnt", squash_cnt, 0);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif
        step(0, 0, 0, 0, 0);
        chk("mid_restart_req", imem_req, 1);
        chk("mid_restart_addr", imem_addr, 0);

        // Random traffic
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
